// File: rtl/cpu_core_membus.sv
// 16-bit-ISA CPU core with an external valid/ready memory bus.
// Registered bus request, bus timeout with error halt, and resume-from-halt.
module cpu_core_membus #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       romData,
    input  logic              resume,
    input  logic              memReady,
    input  logic [DATA_W-1:0] memRdata,
    output logic              memReq,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    output logic [ADDR_W-1:0] programCounter,
    output logic [DATA_W-1:0] displayReg,
    output logic              haltFlag,
    output logic              zeroFlag,
    output logic              carryFlag,
    output logic              busErr
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {EXEC, MEM_WAIT, HALT} stateT;

    stateT             state, stateNext;
    logic [DATA_W-1:0] regFile [8];
    logic [CNT_W-1:0]  waitCnt, waitCntNext;
    logic [2:0]        dstReg, dstNext;

    logic [ADDR_W-1:0] pcNext, memAddrNext;
    logic [DATA_W-1:0] memWdataNext;
    logic              memReqNext, memWeNext;
    logic              zeroNext, carryNext, haltNext, busErrNext;

    logic              wrEn, regWe;
    logic [2:0]        wrIdx;
    logic [DATA_W-1:0] wrData;

    // Instruction fields
    logic [1:0]  cls;
    logic [2:0]  rdIdx, rs1Idx, rs2Idx, ctlOp;
    logic [4:0]  aluOp;
    logic [10:0] imm11;
    logic [6:0]  off7;
    logic        isLoad;

    assign cls    = romData[15:14];
    assign rdIdx  = romData[13:11];
    assign rs1Idx = romData[10:8];
    assign rs2Idx = romData[7:5];
    assign aluOp  = romData[4:0];
    assign ctlOp  = romData[2:0];
    assign imm11  = romData[10:0];
    assign off7   = romData[6:0];
    assign isLoad = romData[7];

    // r7 reads back as the current PC
    logic [DATA_W-1:0] rs1Val, rs2Val, rdVal;
    assign rs1Val = (rs1Idx == 3'd7) ? DATA_W'(programCounter) : regFile[rs1Idx];
    assign rs2Val = (rs2Idx == 3'd7) ? DATA_W'(programCounter) : regFile[rs2Idx];
    assign rdVal  = (rdIdx  == 3'd7) ? DATA_W'(programCounter) : regFile[rdIdx];

    assign displayReg = regFile[6];

    // ALU: bit DATA_W is carry (add carry-out, sub borrow, shifted-out bit)
    logic [DATA_W:0] aluOut;
    logic            condMet;

    always_comb begin
        case (aluOp[2:0])
            3'd0:    aluOut = {1'b0, rs1Val} + {1'b0, rs2Val};
            3'd1:    aluOut = {1'b0, rs1Val} - {1'b0, rs2Val};
            3'd2:    aluOut = {1'b0, rs1Val & rs2Val};
            3'd3:    aluOut = {1'b0, rs1Val | rs2Val};
            3'd4:    aluOut = {1'b0, rs1Val ^ rs2Val};
            3'd5:    aluOut = {rs1Val, 1'b0};
            3'd6:    aluOut = {rs1Val[0], 1'b0, rs1Val[DATA_W-1:1]};
            default: aluOut = {1'b0, rs1Val};
        endcase
        case (aluOp[4:3])
            2'd0:    condMet = 1'b1;
            2'd1:    condMet = zeroFlag;
            2'd2:    condMet = carryFlag;
            default: condMet = ~zeroFlag;
        endcase
    end

    // Next-state and next-register values
    always_comb begin
        stateNext    = state;
        pcNext       = programCounter;
        wrEn         = 1'b0;
        wrIdx        = rdIdx;
        wrData       = aluOut[DATA_W-1:0];
        zeroNext     = zeroFlag;
        carryNext    = carryFlag;
        haltNext     = haltFlag;
        busErrNext   = busErr;
        memReqNext   = memReq;
        memWeNext    = memWe;
        memAddrNext  = memAddr;
        memWdataNext = memWdata;
        waitCntNext  = waitCnt;
        dstNext      = dstReg;

        case (state)
            EXEC: begin
                case (cls)
                    2'b01: begin
                        wrEn   = 1'b1;
                        wrData = DATA_W'(imm11);
                        pcNext = programCounter + ADDR_W'(1);
                    end
                    2'b11: begin
                        pcNext = programCounter + ADDR_W'(1);
                        if (condMet) begin
                            wrEn      = 1'b1;
                            zeroNext  = (aluOut[DATA_W-1:0] == '0);
                            carryNext = aluOut[DATA_W];
                        end
                    end
                    2'b00: begin
                        pcNext = programCounter + ADDR_W'(1);
                        case (ctlOp)
                            3'd0: begin
                                haltNext  = 1'b1;
                                stateNext = HALT;
                            end
                            3'd1:    zeroNext  = 1'b1;
                            3'd2:    zeroNext  = 1'b0;
                            3'd3:    carryNext = 1'b1;
                            3'd4:    carryNext = 1'b0;
                            default: ;
                        endcase
                    end
                    default: begin
                        memAddrNext = ADDR_W'(rs1Val) + ADDR_W'(off7);
                        memWeNext   = ~isLoad;
                        if (!isLoad) memWdataNext = rdVal;
                        dstNext     = rdIdx;
                        memReqNext  = 1'b1;
                        waitCntNext = '0;
                        stateNext   = MEM_WAIT;
                    end
                endcase
            end
            MEM_WAIT: begin
                if (memReady) begin
                    memReqNext = 1'b0;
                    pcNext     = programCounter + ADDR_W'(1);
                    stateNext  = EXEC;
                    if (!memWe) begin
                        wrEn   = 1'b1;
                        wrIdx  = dstReg;
                        wrData = memRdata;
                    end
                end else if (MEM_TIMEOUT != 0 && 32'(waitCnt) + 32'd1 == MEM_TIMEOUT) begin
                    busErrNext = 1'b1;
                    haltNext   = 1'b1;
                    memReqNext = 1'b0;
                    stateNext  = HALT;
                end else begin
                    waitCntNext = waitCnt + CNT_W'(1);
                end
            end
            HALT: begin
                if (resume) begin
                    haltNext   = 1'b0;
                    busErrNext = 1'b0;
                    stateNext  = EXEC;
                end
            end
            default: stateNext = EXEC;
        endcase

        // A write to r7 is a jump and replaces the PC increment
        regWe = wrEn && (wrIdx != 3'd7);
        if (wrEn && wrIdx == 3'd7) pcNext = ADDR_W'(wrData);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= EXEC;
            programCounter <= '0;
            for (int i = 0; i < 8; i++) regFile[i] <= '0;
            zeroFlag       <= 1'b0;
            carryFlag      <= 1'b0;
            haltFlag       <= 1'b0;
            busErr         <= 1'b0;
            memReq         <= 1'b0;
            memWe          <= 1'b0;
            memAddr        <= '0;
            memWdata       <= '0;
            waitCnt        <= '0;
            dstReg         <= '0;
        end else begin
            state          <= stateNext;
            programCounter <= pcNext;
            if (regWe) regFile[wrIdx] <= wrData;
            zeroFlag       <= zeroNext;
            carryFlag      <= carryNext;
            haltFlag       <= haltNext;
            busErr         <= busErrNext;
            memReq         <= memReqNext;
            memWe          <= memWeNext;
            memAddr        <= memAddrNext;
            memWdata       <= memWdataNext;
            waitCnt        <= waitCntNext;
            dstReg         <= dstNext;
        end
    end

endmodule

// File: tb/tb_cpu_core_membus.sv
// Bench for cpu_core_membus: directed program with literal expectations, then
// random program and random bus behaviour checked every cycle against an ISA-level model.
module tb_cpu_core_membus;

    localparam int unsigned DW  = 16;
    localparam int unsigned AW  = 16;
    localparam int unsigned TMO = 8;
    localparam longint unsigned DMASK = (64'd1 << DW) - 1;
    localparam longint unsigned AMASK = (64'd1 << AW) - 1;

    logic          clk = 1'b0;
    logic          rst, resume, memReady;
    logic [15:0]   romData;
    logic [DW-1:0] memRdata, memWdata, displayReg;
    logic [AW-1:0] memAddr, programCounter;
    logic          memReq, memWe, haltFlag, zeroFlag, carryFlag, busErr;

    logic [15:0] rom [256];
    int nErr = 0;
    int nChk = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    assign romData = rom[programCounter[7:0]];

    cpu_core_membus #(.DATA_W(DW), .ADDR_W(AW), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .romData(romData), .resume(resume),
        .memReady(memReady), .memRdata(memRdata),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .programCounter(programCounter), .displayReg(displayReg),
        .haltFlag(haltFlag), .zeroFlag(zeroFlag), .carryFlag(carryFlag), .busErr(busErr)
    );

    task automatic chk(input string name, input logic [63:0] act, input longint unsigned exp);
        nChk++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] encSet(input int rd, input int imm);
        return {2'b01, 3'(rd), 11'(imm)};
    endfunction
    function automatic logic [15:0] encAlu(input int rd, input int a, input int b, input int cnd, input int op);
        return {2'b11, 3'(rd), 3'(a), 3'(b), 2'(cnd), 3'(op)};
    endfunction
    function automatic logic [15:0] encMem(input int ld, input int rd, input int ra, input int off);
        return {2'b10, 3'(rd), 3'(ra), 1'(ld), 7'(off)};
    endfunction
    function automatic logic [15:0] encCtl(input int op);
        return {13'd0, 3'(op)};
    endfunction

    // Architectural model: registers, flags and the outstanding bus request
    longint unsigned mReg [8];
    longint unsigned mPc, mAddr, mWdata, mCnt;
    int  mMode;            // 0 running, 1 waiting on bus, 2 halted
    int  mDst;
    bit  mZ, mC, mH, mE, mReq, mWe;

    function automatic longint unsigned mRd(input int i);
        return (i == 7) ? mPc : mReg[i];
    endfunction

    task automatic mWrite(input int d, input longint unsigned v);
        if (d == 7) mPc = v & AMASK;
        else begin
            mReg[d] = v & DMASK;
            mPc = (mPc + 1) & AMASK;
        end
    endtask

    always @(posedge clk) begin : refModel
        logic [15:0] ins;
        longint unsigned a, b, res, cy;
        bit cond;
        if (rst) begin
            mPc = 0; mZ = 0; mC = 0; mH = 0; mE = 0; mReq = 0; mWe = 0;
            mAddr = 0; mWdata = 0; mCnt = 0; mMode = 0; mDst = 0;
            for (int i = 0; i < 8; i++) mReg[i] = 0;
        end else if (mMode == 0) begin
            ins = rom[mPc[7:0]];
            case (ins[15:14])
                2'b01: mWrite(int'(ins[13:11]), longint'(ins[10:0]));
                2'b11: begin
                    a = mRd(int'(ins[10:8]));
                    b = mRd(int'(ins[7:5]));
                    cy = 0;
                    case (ins[2:0])
                        3'd0: begin res = (a + b) & DMASK; cy = ((a + b) >> DW) & 1; end
                        3'd1: begin res = (a - b) & DMASK; cy = (a < b) ? 1 : 0; end
                        3'd2: res = a & b;
                        3'd3: res = a | b;
                        3'd4: res = a ^ b;
                        3'd5: begin res = (a << 1) & DMASK; cy = (a >> (DW - 1)) & 1; end
                        3'd6: begin res = a >> 1; cy = a & 1; end
                        default: res = a;
                    endcase
                    case (ins[4:3])
                        2'd0: cond = 1;
                        2'd1: cond = mZ;
                        2'd2: cond = mC;
                        default: cond = !mZ;
                    endcase
                    if (cond) begin
                        mZ = (res == 0);
                        mC = cy[0];
                        mWrite(int'(ins[13:11]), res);
                    end else mPc = (mPc + 1) & AMASK;
                end
                2'b00: begin
                    mPc = (mPc + 1) & AMASK;
                    case (ins[2:0])
                        3'd0: begin mH = 1; mMode = 2; end
                        3'd1: mZ = 1;
                        3'd2: mZ = 0;
                        3'd3: mC = 1;
                        3'd4: mC = 0;
                        default: ;
                    endcase
                end
                default: begin
                    mAddr = (mRd(int'(ins[10:8])) + longint'(ins[6:0])) & AMASK;
                    mWe = !ins[7];
                    if (mWe) mWdata = mRd(int'(ins[13:11]));
                    mDst = int'(ins[13:11]);
                    mReq = 1; mCnt = 0; mMode = 1;
                end
            endcase
        end else if (mMode == 1) begin
            if (memReady) begin
                mReq = 0; mMode = 0;
                if (!mWe) mWrite(mDst, longint'(memRdata));
                else mPc = (mPc + 1) & AMASK;
            end else begin
                mCnt++;
                if (TMO != 0 && mCnt == TMO) begin
                    mE = 1; mH = 1; mReq = 0; mMode = 2;
                end
            end
        end else if (resume) begin
            mH = 0; mE = 0; mMode = 0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (started) begin
            chk("pc", 64'(programCounter), mPc);
            chk("display", 64'(displayReg), mReg[6]);
            chk("halt", 64'(haltFlag), 64'(mH));
            chk("zero", 64'(zeroFlag), 64'(mZ));
            chk("carry", 64'(carryFlag), 64'(mC));
            chk("busErr", 64'(busErr), 64'(mE));
            chk("memReq", 64'(memReq), 64'(mReq));
            if (mReq) begin
                chk("memWe", 64'(memWe), 64'(mWe));
                chk("memAddr", 64'(memAddr), mAddr);
                if (mWe) chk("memWdata", 64'(memWdata), mWdata);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int reqCnt;
        int stallLeft;
        int k;

        rom[0] = encSet(1, 'h7FF);
        rom[1] = encSet(2, 5);
        rom[2] = encAlu(3, 1, 2, 0, 0);
        rom[3] = encMem(0, 3, 0, 4);
        rom[4] = encMem(1, 4, 0, 4);
        rom[5] = encCtl(0);
        rom[6] = encAlu(6, 4, 0, 0, 7);
        rom[7] = encMem(1, 5, 0, 9);
        rom[8] = encMem(0, 2, 0, 1);
        rom[9] = encSet(7, 16);
        for (int i = 10; i < 256; i++) begin
            k = int'($urandom_range(0, 99));
            if (k < 25)      rom[i] = encSet(int'($urandom_range(0, 7)), int'($urandom_range(0, 2047)));
            else if (k < 55) rom[i] = encAlu(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                                             int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                                             int'($urandom_range(0, 7)));
            else if (k < 85) rom[i] = encMem(int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                                             int'($urandom_range(0, 7)), int'($urandom_range(0, 127)));
            else             rom[i] = encCtl(int'($urandom_range(0, 7)));
        end

        rst = 1'b1; resume = 1'b0; memReady = 1'b0; memRdata = '0;
        step(); step();
        started = 1'b1;
        chk("reset_pc", 64'(programCounter), 0);
        chk("reset_req", 64'(memReq), 0);
        chk("reset_flags", 64'({haltFlag, zeroFlag, carryFlag, busErr}), 0);
        chk("reset_display", 64'(displayReg), 0);
        rst = 1'b0;

        // SET, SET, ADD
        step(); step(); step();
        chk("add_pc", 64'(programCounter), 3);
        chk("add_flags", 64'({zeroFlag, carryFlag}), 0);

        // Store with three not-ready cycles
        step();
        reqCnt = int'(memReq);
        chk("st_we", 64'(memWe), 1);
        chk("st_addr", 64'(memAddr), 4);
        chk("st_wdata", 64'(memWdata), 'h804);
        repeat (3) begin
            step();
            reqCnt += int'(memReq);
        end
        chk("st_pc_hold", 64'(programCounter), 3);
        memReady = 1'b1;
        step();
        chk("st_done_req", 64'(memReq), 0);
        chk("st_done_pc", 64'(programCounter), 4);
        chk("st_req_cycles", 64'(reqCnt), 4);

        // Load with memReady tied high: two cycles
        memRdata = DW'(16'hBEEF);
        step();
        chk("ld_req", 64'(memReq), 1);
        chk("ld_we", 64'(memWe), 0);
        step();
        chk("ld_pc", 64'(programCounter), 5);
        chk("ld_req_drop", 64'(memReq), 0);
        memReady = 1'b0;

        // HLT at PC 5
        step();
        chk("hlt_flag", 64'(haltFlag), 1);
        chk("hlt_pc", 64'(programCounter), 6);
        repeat (10) step();
        chk("hlt_frozen_pc", 64'(programCounter), 6);
        chk("hlt_frozen_flag", 64'(haltFlag), 1);
        resume = 1'b1;
        step();
        resume = 1'b0;
        chk("resume_flag", 64'(haltFlag), 0);
        step();
        chk("mov_display", 64'(displayReg), 'hBEEF);
        chk("mov_pc", 64'(programCounter), 7);

        // Load that times out; resume while running is ignored
        resume = 1'b1;
        step();
        resume = 1'b0;
        chk("to_req", 64'(memReq), 1);
        chk("to_nohalt", 64'(haltFlag), 0);
        repeat (7) step();
        chk("to_before", 64'({busErr, memReq}), 1);
        step();
        chk("to_buserr", 64'(busErr), 1);
        chk("to_halt", 64'(haltFlag), 1);
        chk("to_req_drop", 64'(memReq), 0);
        chk("to_pc", 64'(programCounter), 7);
        resume = 1'b1;
        step();
        resume = 1'b0;
        chk("to_clear", 64'({busErr, haltFlag}), 0);
        step();
        chk("retry_req", 64'(memReq), 1);
        chk("retry_addr", 64'(memAddr), 9);
        memReady = 1'b1;
        memRdata = DW'(16'h1234);
        step();
        chk("retry_pc", 64'(programCounter), 8);
        memReady = 1'b0;

        // Reset while waiting on a store
        step();
        chk("st2_wdata", 64'(memWdata), 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_req", 64'(memReq), 0);
        chk("rst_pc", 64'(programCounter), 0);
        chk("rst_display", 64'(displayReg), 0);
        memReady = 1'b1;
        step();
        chk("rst_ready_ignored", 64'(memReq), 0);
        chk("rst_pc_run", 64'(programCounter), 1);

        // Random bus timing, resumes and one reset
        stallLeft = 0;
        for (int i = 0; i < 4000; i++) begin
            if (stallLeft > 0) begin
                memReady = 1'b0;
                stallLeft--;
            end else begin
                memReady = ($urandom_range(0, 2) != 0);
                if ($urandom_range(0, 40) == 0) stallLeft = 12;
            end
            memRdata = DW'($urandom);
            resume = ($urandom_range(0, 5) == 0);
            rst = (i == 2500);
            step();
        end
        rst = 1'b0;
        resume = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", nErr, nChk);
        $finish;
    end

endmodule
